// File: rtl/viterbi_out_pkg.sv
// viterbi_out_pkg: shared types for the Viterbi decoded-bit output scheduler.
// Holds the FSM state enum, default sizes and the FIFO word struct {last, data}.
package viterbi_out_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_LEN_W      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } word_t;

endpackage

// File: rtl/viterbi_out_fifo.sv
// viterbi_out_fifo: synchronous word FIFO (no fall-through) with full/empty/count.
// Ports: i_clk, i_rst_n, i_push/i_din, i_pop/o_dout (head), o_full, o_empty, o_count.
module viterbi_out_fifo
    import viterbi_out_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type T     = word_t
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  T                       i_din,
    input  logic                   i_pop,
    output T                       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    cnt_q;
    logic           do_push;
    logic           do_pop;

    assign o_full  = cnt_q == (AW+1)'(DEPTH);
    assign o_empty = cnt_q == '0;
    assign o_count = cnt_q;
    assign o_dout  = mem[rd_q];

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_q] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/viterbi_out_sched.sv
// viterbi_out_sched: packs decoded bits into DATA_W words, buffers and emits them.
// Ports: i_frame_start/i_frame_len (frame setup), i_bit_valid/i_bit/o_bit_ready
// (bit input), o_valid/o_data/o_last/i_ready (word output), o_busy, o_frame_done.
// Build option: define VITERBI_OUT_LSB_FIRST_EN for LSB-first packing.
module viterbi_out_sched
    import viterbi_out_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic [LEN_W-1:0]  i_frame_len,
    input  logic              i_bit_valid,
    input  logic              i_bit,
    output logic              o_bit_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int IW = $clog2(DATA_W);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } wrd_t;

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  total_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     pos;
    logic [DATA_W-1:0] pack_q;
    logic [DATA_W-1:0] pack_nx;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    wrd_t              push_w;
    wrd_t              head;

    logic              start_ok;
    logic              start_nil;
    logic              pop;
    logic              pop_last;
    logic              acc;
    logic              word_end;
    logic              bit_last;
    logic              push;

    assign start_ok  = (state_q == IDLE) && i_frame_start
                       && (i_frame_len != '0);
    assign start_nil = (state_q == IDLE) && i_frame_start
                       && (i_frame_len == '0);

    assign pop      = o_valid && i_ready;
    assign pop_last = pop && head.last;

    assign o_bit_ready = (state_q == COLLECT) && (!fifo_full || pop);
    assign acc         = i_bit_valid && o_bit_ready;

    assign word_end = idx_q == IW'(DATA_W - 1);
    // total_q never exceeds len_q, so len_q-1 cannot wrap while collecting.
    assign bit_last = total_q == (len_q - LEN_W'(1));
    assign push     = acc && (word_end || bit_last);

`ifdef VITERBI_OUT_LSB_FIRST_EN
    assign pos = idx_q;
`else
    assign pos = IW'(DATA_W - 1) - idx_q;
`endif

    // Pack register never holds the current bit; merge it here for the push.
    always_comb begin
        pack_nx      = pack_q;
        pack_nx[pos] = i_bit;
    end

    assign push_w = '{last: bit_last, data: pack_nx};

    viterbi_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wrd_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_din   (push_w),
        .i_pop   (pop),
        .o_dout  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_cnt)
    );

    assign o_valid = fifo_cnt != '0;
    assign o_data  = fifo_empty ? '0 : head.data;
    assign o_last  = fifo_empty ? 1'b0 : head.last;
    assign o_busy  = state_q != IDLE;

    // Zero-length frames finish one cycle after the strobe; real frames
    // finish in the same cycle their last word leaves.
    assign o_frame_done = done_q || ((state_q == DRAIN) && pop_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (push && bit_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q   <= '0;
            total_q <= '0;
            idx_q   <= '0;
            pack_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= start_nil;
            if (start_ok) begin
                len_q   <= i_frame_len;
                total_q <= '0;
                idx_q   <= '0;
                pack_q  <= '0;
            end else if (acc) begin
                total_q <= total_q + LEN_W'(1);
                if (push) begin
                    idx_q  <= '0;
                    pack_q <= '0;
                end else begin
                    idx_q  <= idx_q + IW'(1);
                    pack_q <= pack_nx;
                end
            end
        end
    end

endmodule
